// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encodings (tx now, rx later).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: divisor latched on load (0/1 clamp to 2), counts 0..N-1.
// bit_end is combinational and marks the last cycle of every bit while running.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             bit_end
);

  logic [DIV_W-1:0] n_q;
  logic [DIV_W-1:0] cnt_q;

  assign bit_end = run && (cnt_q == n_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= DIV_W'(2);
      cnt_q <= '0;
    end else if (load) begin
      n_q   <= (div < DIV_W'(2)) ? DIV_W'(2) : div;
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= bit_end ? '0 : cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding buffer for gapless frames.
// Word captured at edge k starts its START bit on o_tx at k+2; o_ready low while the buffer is full.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DIV_W-1:0]     i_clks_per_bit,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_dbg_state
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_cfg: illegal DATA_BITS/PARITY/STOP_BITS combination");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] buf_q;
  logic                 buf_full_q, buf_full_d;
  logic                 ready_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 load;
  logic                 shift_en;
  logic                 last_stop;
  logic                 bit_end;
  logic                 capture;

  assign capture    = i_valid && ready_q;
  assign buf_full_d = capture || (buf_full_q && !load);

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .div     (i_clks_per_bit),
    .run     (state_q != ST_IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    last_stop = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            // Reload on the final stop cycle so the next START follows with no idle bit.
            last_stop = 1'b1;
            bit_cnt_d = '0;
            if (buf_full_q) begin
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      buf_full_q <= buf_full_d;
      ready_q    <= !buf_full_d;
      if (capture) begin
        buf_q <= i_data;
      end
      if (load) begin
        shift_q <= buf_q;
        par_q   <= (PARITY == PARITY_ODD) ? ~^buf_q : ^buf_q;
      end else if (shift_en) begin
        shift_q <= shift_q >> 1;
      end
      // Line outputs trail the state register by one cycle; o_done lines up with the last stop cycle.
      tx_q   <= tx_d;
      busy_q <= (state_q != ST_IDLE);
      done_q <= last_stop;
    end
  end

  assign o_ready     = ready_q;
  assign o_tx        = tx_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule
